// File: rtl/dac_pkg.sv
// Shared definitions for the dual serial DAC frame controller.
//   FRAME_W / DATA_W : serial word width and sample width per channel
//   PD_*             : DAC power-down field encodings
//   state_t          : controller FSM states
//   build_frame()    : assembles the 16-bit word {2'b00, pd, data}
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]        pd,
                                                       input logic [DATA_W-1:0] data);
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period divider for the serial clock.
//   clk, rst : system clock, asynchronous active-low reset
//   clr      : synchronous clear, restarts the half-period count
//   en       : count enable
//   tick     : one-cycle pulse every CLK_DIV enabled cycles
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Combinational tick so the consumer acts on the edge that completes the count.
    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dual_dac_frame_ctrl.sv
// Two-channel serial DAC frame controller. Accepts one A/B sample pair per
// valid/ready handshake and shifts both 16-bit words out in lockstep on a
// shared SCLK, framed by NSYNC, followed by an NSYNC-high gap.
//   clk, rst             : system clock, asynchronous active-low reset
//   s_valid / s_ready    : upstream handshake for one sample pair
//   s_data_a, s_data_b   : channel codes for SDATA1 / SDATA2
//   pd_mode              : power-down bits, captured at accept
//   SCLK, SDATA1, SDATA2 : serial clock (idles high) and data
//   NSYNC                : frame sync, active low
//   busy                 : accept through return to IDLE
//   frame_done           : one-cycle pulse on return to IDLE
module dual_dac_frame_ctrl
    import dac_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int GAP_SCLK = 1,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data_a,
    input  logic [DATA_W-1:0] s_data_b,
    input  logic [1:0]        pd_mode,
    output logic              SCLK,
    output logic              SDATA1,
    output logic              SDATA2,
    output logic              NSYNC,
    output logic              busy,
    output logic              frame_done
);

    generate
        if (CLK_DIV < 1 || GAP_SCLK < 1) begin : g_bad_timing
            $error("dual_dac_frame_ctrl: CLK_DIV and GAP_SCLK must be >= 1");
        end
        if (DATA_W != 12) begin : g_bad_width
            $error("dual_dac_frame_ctrl: DATA_W must be 12");
        end
    endgenerate

    // One counter serves both phases: 32 half-period ticks while shifting,
    // 2*GAP_SCLK ticks while holding NSYNC high.
    localparam int TICK_MAX = (2 * GAP_SCLK > 2 * FRAME_W) ? 2 * GAP_SCLK : 2 * FRAME_W;
    localparam int CNT_W    = $clog2(TICK_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(2 * FRAME_W);
    localparam logic [CNT_W-1:0] GAP_TICKS = CNT_W'(2 * GAP_SCLK);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_a_q, sr_a_d;
    logic [FRAME_W-1:0] sr_b_q, sr_b_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d, tnext;
    logic               sclk_q, sclk_d;
    logic               nsync_q, nsync_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_clr, tick;

    sclk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .en  (state_q != IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            tcnt_q  <= '0;
            sclk_q  <= 1'b1;
            nsync_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_a_q  <= sr_a_d;
            sr_b_q  <= sr_b_d;
            tcnt_q  <= tcnt_d;
            sclk_q  <= sclk_d;
            nsync_q <= nsync_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_a_d  = sr_a_q;
        sr_b_d  = sr_b_q;
        tcnt_d  = tcnt_q;
        sclk_d  = sclk_q;
        nsync_d = nsync_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        div_clr = 1'b0;
        tnext   = tcnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (s_valid && ready_q) begin
                    sr_a_d  = build_frame(pd_mode, s_data_a);
                    sr_b_d  = build_frame(pd_mode, s_data_b);
                    nsync_d = 1'b0;
                    sclk_d  = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    tcnt_d  = '0;
                    div_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    tcnt_d = tnext;
                    if (tnext[0]) begin
                        // Odd tick: falling SCLK, DAC samples the bit now on SDATA.
                        sclk_d = 1'b0;
                    end else if (tnext == LAST_TICK) begin
                        sclk_d  = 1'b1;
                        nsync_d = 1'b1;
                        sr_a_d  = '0;
                        sr_b_d  = '0;
                        tcnt_d  = '0;
                        state_d = GAP;
                    end else begin
                        sclk_d = 1'b1;
                        sr_a_d = {sr_a_q[FRAME_W-2:0], 1'b0};
                        sr_b_d = {sr_b_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    tcnt_d = tnext;
                    if (tnext == GAP_TICKS) begin
                        tcnt_d  = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready    = ready_q;
    assign SCLK       = sclk_q;
    assign NSYNC      = nsync_q;
    assign SDATA1     = sr_a_q[FRAME_W-1];
    assign SDATA2     = sr_b_q[FRAME_W-1];
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
